// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial add/subtract engine built around one full-adder
//               slice, sequenced by an IDLE/RUN/DONE state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic w_x;
    logic w_y;
    logic w_s;
    logic w_co;

    // Single full-adder slice fed by the operand LSBs and the carry FF.
    assign w_x  = r_a[0];
    assign w_y  = r_b[0];
    assign w_s  = w_x ^ w_y ^ r_carry;
    assign w_co = (w_x & w_y) | (r_carry & (w_x ^ w_y));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed carry with 1.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last_bit) begin
                        // On the MSB, r_carry is the carry into the sign bit.
                        r_sum   <= {w_s, r_res[WIDTH-1:1]};
                        r_cout  <= w_co;
                        r_ovf   <= r_carry ^ w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Scoreboard bench for serial_adder_ctrl (WIDTH=8): directed
//               vectors push expected results, a monitor checks each done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        string            nm;
    } exp_t;

    exp_t             sb_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc   = 0;
    logic [WIDTH-1:0] last_sum = '0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.nm, " sum"},  32'(sum),  32'(e.s));
                check({e.nm, " cout"}, 32'(cout), 32'(e.c));
                check({e.nm, " ovf"},  32'(ovf),  32'(e.v));
                check({e.nm, " busy@done"}, 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one operation from idle and check latency, busy width and hold.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tsub,
                         input logic [7:0] es, input logic ec, input logic ev, input string nm);
        int k;
        int nbusy;
        bit seen;
        bit stable;
        @(negedge clk);
        a = ta; b = tb_; sub = tsub; start = 1'b1;
        sb_q.push_back('{es, ec, ev, nm});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1; nbusy = 0; seen = 0; stable = 1;
        while (!seen && k <= 20) begin
            if (done) seen = 1;
            else begin
                if (busy) nbusy++;
                if (sum !== last_sum) stable = 0;
                @(negedge clk);
                k++;
            end
        end
        check({nm, " latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'd9);
        check({nm, " busy cycles"}, 32'(nbusy), 32'd8);
        check({nm, " sum held"}, 32'(stable), 32'd1);
        last_sum = es;
        @(negedge clk);
        check({nm, " done width"}, 32'(done), 32'd0);
    endtask

    function automatic void model(input logic [7:0] ta, input logic [7:0] tb_, input logic tsub,
                                  output logic [7:0] s, output logic c, output logic v);
        logic [8:0] t;
        if (tsub) begin
            s = ta - tb_;
            c = (ta >= tb_);
            v = (ta[7] != tb_[7]) && (s[7] != ta[7]);
        end else begin
            t = {1'b0, ta} + {1'b0, tb_};
            s = t[7:0];
            c = t[8];
            v = (ta[7] == tb_[7]) && (s[7] != ta[7]);
        end
    endfunction

    initial begin
        logic [7:0] oa[6];
        logic [7:0] ob[6];
        logic       osub[6];
        logic [7:0] os[6];
        logic       oc[6];
        logic       ov[6];
        int         k;
        int         ndone;
        int         last_cyc;
        bit         busy_ok;
        bit         gap_ok;
        logic [7:0] ra, rb, rs;
        logic       rsub, rc, rv;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        // start while in reset must be ignored
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum",  32'(sum),  32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf",  32'(ovf),  32'd0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset busy", 32'(busy), 32'd0);

        do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add 0F+01");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add FF+01");
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add 7F+01");
        do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub 05-07");
        do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01");

        // start re-asserted mid-operation must be ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        sb_q.push_back('{8'h46, 1'b0, 1'b0, "ignore-start 12+34"});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k <= 20) begin
            if (k == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
            else start = 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("ignore-start latency", 32'(k), 32'd9);
        last_sum = 8'h46;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignore-start extra done", 32'(ndone), 32'd0);

        // asynchronous reset in the middle of RUN aborts the operation
        @(negedge clk);
        a = 8'h21; b = 8'h13; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort sum",  32'(sum),  32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_sum = '0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);
        do_op(8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0, "after abort 21+13");

        // back-to-back with start held high
        oa = '{8'h01, 8'h10, 8'hA5, 8'h00, 8'h80, 8'h7F};
        ob = '{8'h02, 8'h01, 8'h5A, 8'h01, 8'h80, 8'hFF};
        osub = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        os = '{8'h03, 8'h0F, 8'hFF, 8'hFF, 8'h00, 8'h80};
        oc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        a = oa[0]; b = ob[0]; sub = osub[0]; start = 1'b1;
        sb_q.push_back('{os[0], oc[0], ov[0], "b2b op0"});
        @(posedge clk);
        @(negedge clk);
        busy_ok = 1; gap_ok = 1; last_cyc = -1; ndone = 0; k = 0;
        while (ndone < 6 && k < 100) begin
            if (done) begin
                if (last_cyc >= 0 && (cyc - last_cyc) != 9) gap_ok = 0;
                last_cyc = cyc;
                ndone++;
                if (ndone < 6) begin
                    a = oa[ndone]; b = ob[ndone]; sub = osub[ndone];
                    sb_q.push_back('{os[ndone], oc[ndone], ov[ndone], $sformatf("b2b op%0d", ndone)});
                end else begin
                    start = 1'b0;
                end
            end else if (!busy) begin
                busy_ok = 0;
            end
            @(negedge clk);
            k++;
        end
        check("b2b done count", 32'(ndone), 32'd6);
        check("b2b done spacing", 32'(gap_ok), 32'd1);
        check("b2b busy pattern", 32'(busy_ok), 32'd1);
        last_sum = os[5];

        // random operations against the reference model
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rsub = 1'($urandom);
            model(ra, rb, rsub, rs, rc, rv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(ra, rb, rsub, rs, rc, rv, $sformatf("rand%0d", i));
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
